// File: rtl/data_read_controller_multi.sv
// rtl/data_read_controller_multi.sv - FIFO-to-scratchpad read controller with length, base address, wrap and abort
module data_read_controller_multi #(
   parameter int DATA_W     = 16,
   parameter int SPAD_DEPTH = 12,
   parameter int ADDR_W     = 4,
   parameter int LEN_W      = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_read,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              abort,
   input  logic              valid,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              done,
   output logic              ren,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              read_buf,
   output logic              finish_read,
   output logic              busy,
   output logic [LEN_W-1:0]  words_written
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_V = 3'd1,
      LATCH  = 3'd2,
      WRITE  = 3'd3,
      POP    = 3'd4,
      FINISH = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPAD_DEPTH - 1);

   state_t            state;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  cnt_inc;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;

   assign cnt_inc       = cnt + LEN_W'(1);
   assign waddr         = addr_r;
   assign wdata         = data_r;
   assign words_written = cnt;

   // FSM: state, datapath registers and Moore outputs registered from the state being entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         len_r       <= '0;
         cnt         <= '0;
         addr_r      <= '0;
         data_r      <= '0;
         ren         <= 1'b0;
         wen         <= 1'b0;
         read_buf    <= 1'b0;
         finish_read <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ren         <= 1'b0;
         wen         <= 1'b0;
         read_buf    <= 1'b0;
         finish_read <= 1'b0;
         busy        <= 1'b1;
         case (state)
            IDLE: begin
               if (start_read) begin
                  len_r  <= len;
                  addr_r <= base_addr;
                  cnt    <= '0;
                  if (len == '0) begin
                     state       <= FINISH;
                     finish_read <= 1'b1;
                  end else begin
                     state <= WAIT_V;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            WAIT_V: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (valid) begin
                  state    <= LATCH;
                  read_buf <= 1'b1;
               end
            end
            LATCH: begin
               data_r <= fifo_data;
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= WRITE;
                  wen   <= 1'b1;
               end
            end
            WRITE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= POP;
                  ren   <= 1'b1;
               end
            end
            POP: begin
               // The pop has already happened this cycle, so the word is counted even on abort
               cnt    <= cnt_inc;
               addr_r <= (addr_r == LAST_ADDR) ? '0 : addr_r + ADDR_W'(1);
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt_inc == len_r) begin
                  state       <= FINISH;
                  finish_read <= 1'b1;
               end else begin
                  state <= WAIT_V;
               end
            end
            FINISH: begin
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  finish_read <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_read_controller_multi.sv
// tb/tb_data_read_controller_multi.sv - directed self-checking bench for data_read_controller_multi
module tb_data_read_controller_multi;

   logic        clk;
   logic        rst_n;
   logic        start_read;
   logic [4:0]  len;
   logic [3:0]  base_addr;
   logic        abort;
   logic        valid;
   logic [15:0] fifo_data;
   logic        done;
   logic        ren;
   logic        wen;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic        read_buf;
   logic        finish_read;
   logic        busy;
   logic [4:0]  words_written;

   int n_vec = 0;
   int n_err = 0;

   data_read_controller_multi #(
      .DATA_W(16), .SPAD_DEPTH(12), .ADDR_W(4), .LEN_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_read(start_read), .len(len),
      .base_addr(base_addr), .abort(abort), .valid(valid), .fifo_data(fifo_data),
      .done(done), .ren(ren), .wen(wen), .waddr(waddr), .wdata(wdata),
      .read_buf(read_buf), .finish_read(finish_read), .busy(busy),
      .words_written(words_written)
   );

   // free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   // launch a transfer from IDLE; returns in the first WAIT_V cycle (or FINISH for len 0)
   task automatic start(input logic [4:0] l, input logic [3:0] b);
      len        = l;
      base_addr  = b;
      start_read = 1'b1;
      tick();
      start_read = 1'b0;
   endtask

   // one word from WAIT_V with valid high: LATCH, WRITE, POP, then the next state
   task automatic do_word(input string tag, input logic [3:0] a, input logic [15:0] d);
      fifo_data = d;
      tick();
      check({tag, ".latch_rb"}, read_buf, 1'b1);
      check({tag, ".latch_wen"}, wen, 1'b0);
      tick();
      check({tag, ".write_wen"}, wen, 1'b1);
      check({tag, ".write_addr"}, waddr, a);
      check({tag, ".write_data"}, wdata, d);
      check({tag, ".write_ren"}, ren, 1'b0);
      tick();
      check({tag, ".pop_ren"}, ren, 1'b1);
      check({tag, ".pop_wen"}, wen, 1'b0);
      tick();
   endtask

   // acknowledge a finished transfer and confirm return to IDLE
   task automatic finish(input string tag, input logic [4:0] ww);
      check({tag, ".fin"}, finish_read, 1'b1);
      check({tag, ".fin_ww"}, words_written, ww);
      done = 1'b1;
      tick();
      done = 1'b0;
      check({tag, ".idle_fin"}, finish_read, 1'b0);
      check({tag, ".idle_busy"}, busy, 1'b0);
      check({tag, ".idle_ww"}, words_written, ww);
   endtask

   initial begin
      rst_n = 1'b0; start_read = 1'b0; len = '0; base_addr = '0; abort = 1'b0;
      valid = 1'b0; fifo_data = '0; done = 1'b0;
      tick(); tick();
      check("rst.busy", busy, 1'b0);
      check("rst.ren", ren, 1'b0);
      check("rst.wen", wen, 1'b0);
      check("rst.rb", read_buf, 1'b0);
      check("rst.fin", finish_read, 1'b0);
      check("rst.waddr", waddr, 4'd0);
      check("rst.ww", words_written, 5'd0);
      rst_n = 1'b1;
      tick();

      // basic transfer: len 3 from address 0
      valid = 1'b1;
      start(5'd3, 4'd0);
      check("basic.busy", busy, 1'b1);
      check("basic.wait_wen", wen, 1'b0);
      do_word("basic.w0", 4'd0, 16'h0011);
      check("basic.ww1", words_written, 5'd1);
      do_word("basic.w1", 4'd1, 16'h0022);
      do_word("basic.w2", 4'd2, 16'h0033);
      finish("basic", 5'd3);

      // wrap-around at depth 12
      start(5'd4, 4'd10);
      do_word("wrap.w0", 4'd10, 16'h00A0);
      do_word("wrap.w1", 4'd11, 16'h00A1);
      do_word("wrap.w2", 4'd0, 16'h00A2);
      do_word("wrap.w3", 4'd1, 16'h00A3);
      finish("wrap", 5'd4);

      // zero length: finish the cycle after start, held until done
      start(5'd0, 4'd3);
      check("zero.ww", words_written, 5'd0);
      for (int i = 0; i < 5; i++) begin
         check("zero.hold_fin", finish_read, 1'b1);
         check("zero.hold_wen", wen, 1'b0);
         check("zero.hold_ren", ren, 1'b0);
         if (i < 4) tick();
      end
      finish("zero", 5'd0);

      // stall: valid low for 6 cycles before the second word
      start(5'd3, 4'd5);
      do_word("stall.w0", 4'd5, 16'h0051);
      valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stall.ren", ren, 1'b0);
         check("stall.wen", wen, 1'b0);
         check("stall.rb", read_buf, 1'b0);
         check("stall.busy", busy, 1'b1);
      end
      valid = 1'b1;
      do_word("stall.w1", 4'd6, 16'h0052);
      do_word("stall.w2", 4'd7, 16'h0053);
      finish("stall", 5'd3);

      // abort in WRITE of word 2 of 5
      start(5'd5, 4'd0);
      do_word("abort.w0", 4'd0, 16'h0061);
      fifo_data = 16'h0062;
      tick();
      check("abort.latch_rb", read_buf, 1'b1);
      tick();
      check("abort.write_wen", wen, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort.busy", busy, 1'b0);
      check("abort.ren", ren, 1'b0);
      check("abort.ww", words_written, 5'd1);
      for (int i = 0; i < 3; i++) begin
         check("abort.no_fin", finish_read, 1'b0);
         tick();
      end

      // reset mid-transfer, then a normal len 2 transfer
      start(5'd4, 4'd3);
      do_word("mrst.w0", 4'd3, 16'h0077);
      fifo_data = 16'h0078;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst.busy", busy, 1'b0);
      check("mrst.ren", ren, 1'b0);
      check("mrst.wen", wen, 1'b0);
      check("mrst.rb", read_buf, 1'b0);
      check("mrst.fin", finish_read, 1'b0);
      check("mrst.waddr", waddr, 4'd0);
      check("mrst.wdata", wdata, 16'h0000);
      check("mrst.ww", words_written, 5'd0);
      start(5'd2, 4'd8);
      do_word("post.w0", 4'd8, 16'h0081);
      do_word("post.w1", 4'd9, 16'h0082);
      finish("post", 5'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_read_controller_multi.md
Name: data_read_controller_multi

Overview:
- Parametrised successor to the PE scratchpad-fill FSM.
- Moves a programmable number of words from an input FIFO into a PE scratchpad: pop, latch, write, repeat.
- Generates scratchpad write addresses internally, with a base offset and wrap-around at the scratchpad depth.
- Counts words itself, supports abort, and reports progress; the external "all data read" strobe is no longer needed.

Parameters:
- DATA_W, 16, width of FIFO data and scratchpad write data.
- SPAD_DEPTH, 12, scratchpad depth; write address wraps from SPAD_DEPTH-1 to 0.
- ADDR_W, 4, scratchpad address width; must satisfy 2^ADDR_W >= SPAD_DEPTH.
- LEN_W, 5, transfer-length width; lengths 0..2^LEN_W-1 are legal.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start_read  in  1  transfer request; sampled only in IDLE.
- len  in  LEN_W  word count; latched when start_read is accepted.
- base_addr  in  ADDR_W  first write address; latched on start; must be < SPAD_DEPTH.
- abort  in  1  cancels the transfer; returns to IDLE with no finish_read.
- valid  in  1  FIFO non-empty.
- fifo_data  in  DATA_W  FIFO head word.
- done  in  1  downstream acknowledge of finish_read.
- ren  out  1  FIFO pop strobe, one cycle.
- wen  out  1  scratchpad write strobe, one cycle.
- waddr  out  ADDR_W  scratchpad write address.
- wdata  out  DATA_W  scratchpad write data (latched word).
- read_buf  out  1  high in the cycle fifo_data is latched.
- finish_read  out  1  transfer complete; held until done.
- busy  out  1  high in every state except IDLE.
- words_written  out  LEN_W  words written so far in the current transfer.

Behaviour:
- Reset (rst_n=0 at a clock edge, in any state, including mid-transfer):
  - State goes to IDLE.
  - ren, wen, read_buf, finish_read and busy are 0.
  - waddr, words_written and wdata are 0.
  - All latched len/base values are cleared.
- States: IDLE, WAIT_V, LATCH, WRITE, POP, FINISH.
- State outputs are Moore; waddr and wdata come from registers.
- IDLE:
  - On start_read, latch len into len_r, set addr_r=base_addr and cnt=0.
  - Next state is FINISH if len==0, else WAIT_V.
- WAIT_V: stay while valid=0; go to LATCH when valid=1.
- LATCH:
  - read_buf=1; data_r<=fifo_data.
  - Always go to WRITE.
- WRITE:
  - wen=1, waddr=addr_r, wdata=data_r.
  - Always go to POP.
- POP:
  - ren=1.
  - cnt<=cnt+1.
  - addr_r<=(addr_r==SPAD_DEPTH-1) ? 0 : addr_r+1.
  - Next state is FINISH if cnt+1==len_r, else WAIT_V.
- FINISH: finish_read=1; stay until done=1, then go to IDLE on the next edge.
- Throughput: 4 cycles per word minimum (WAIT_V, LATCH, WRITE, POP) when valid is already high.
  - Latency from start_read to the first wen is 3 cycles with valid high.
- words_written = cnt. It holds its value through FINISH and clears on the next accepted start.
- abort:
  - In WAIT_V, LATCH, WRITE or POP: next state is IDLE, with priority over all other transitions.
  - An abort in POP still performs that cycle's ren, because the output is Moore.
  - No finish_read is issued.
  - abort is ignored in IDLE and FINISH.
- start_read outside IDLE is ignored. start_read and done arriving together in FINISH go to IDLE only; a new start is accepted in IDLE.
- valid dropping after LATCH has no effect: the word is already latched.
- len==2^LEN_W-1 with SPAD_DEPTH smaller wraps and overwrites. This is legal and no error is raised.
- ren is never asserted without a preceding LATCH of the same word. FIFO underflow is therefore impossible while valid is honoured.

Test Plan:
- Basic transfer: valid=1 constant, start_read with len=3, base_addr=0.
  - Expect wen at waddr 0,1,2, each followed by ren, spaced 4 cycles apart.
  - finish_read rises after the third POP; words_written=3.
  - done pulse returns the FSM to IDLE one cycle later.
- Wrap-around: SPAD_DEPTH=12, base_addr=10, len=4, fifo_data=0xA0..0xA3.
  - Expect writes (10,0xA0), (11,0xA1), (0,0xA2), (1,0xA3).
- Zero length: len=0.
  - Expect finish_read the cycle after start with no wen or ren.
  - finish_read holds for 5 cycles until done is asserted.
- Stall: valid low for 6 cycles before the second word.
  - Expect the FSM to stay in WAIT_V with no ren, wen or read_buf.
  - Transfer resumes and completes with correct addresses.
- Abort and reset:
  - Abort in WRITE of word 2 of 5: IDLE next cycle, finish_read never asserted, words_written=1.
  - Separately, rst_n=0 mid-transfer: all outputs 0 on the next edge.
  - A new start with len=2 then completes normally.
